// File: rtl/fu_issue_sched.sv
// Purpose : issue scheduler sharing the ALU, memory and multiplier units across NUM_RS RS banks.
// Latency : grants are combinational from rdy inputs and current state (same-cycle issue).
// Backpr. : a busy unit, cdb_stall or flush withholds grants; banks simply re-request next cycle.
//
// Ports   : clk/reset (async, active-low); rs_{alu,mem,mult}_rdy per-bank requests;
//           cdb_stall, mem_done, flush status; ALU_free/mem_free/mult_free one-hot-or-zero
//           grants; mult_busy and mem_state expose unit occupancy.
// Option  : define FU_SCHED_PERF_EN to add saturating 16-bit grant and stall counters.
module fu_issue_sched #(
  parameter int NUM_RS   = 2,
  parameter int MULT_LAT = 4,
  parameter int PTR_W    = (NUM_RS > 1) ? $clog2(NUM_RS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_RS-1:0] rs_alu_rdy,
  input  logic [NUM_RS-1:0] rs_mem_rdy,
  input  logic [NUM_RS-1:0] rs_mult_rdy,
  input  logic              cdb_stall,
  input  logic              mem_done,
  input  logic              flush,
  output logic [NUM_RS-1:0] ALU_free,
  output logic [NUM_RS-1:0] mem_free,
  output logic [NUM_RS-1:0] mult_free,
  output logic              mult_busy,
  output logic [1:0]        mem_state
`ifdef FU_SCHED_PERF_EN
  ,
  output logic [15:0]       alu_grant_cnt,
  output logic [15:0]       mem_grant_cnt,
  output logic [15:0]       mult_grant_cnt,
  output logic [15:0]       stall_cnt
`endif
);

  localparam int CNT_W = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;

  typedef enum logic [1:0] {
    MEM_IDLE  = 2'd0,
    MEM_BUSY  = 2'd1,
    MEM_DRAIN = 2'd2,
    MEM_BAD   = 2'd3
  } mem_st_e;

  mem_st_e          mem_st_q, mem_st_d;
  logic [CNT_W-1:0] mult_cnt_q, mult_cnt_d;
  logic [PTR_W-1:0] ptr_mult_q, ptr_mult_d;
  logic [PTR_W-1:0] ptr_mem_q, ptr_mem_d;
  logic [PTR_W-1:0] ptr_alu_q, ptr_alu_d;

  logic              mult_avail, mem_avail, alu_avail;
  logic              mult_hit, mem_hit, alu_hit;
  logic [PTR_W-1:0]  mult_win, mem_win, alu_win;
  logic [NUM_RS-1:0] mult_gnt, mem_gnt, alu_gnt;

  // Round-robin search from ptr upward; returns {found, winner}.
  function automatic logic [PTR_W:0] rr_pick(input logic [NUM_RS-1:0] req,
                                             input logic [PTR_W-1:0]  ptr);
    logic             found;
    logic [PTR_W-1:0] win;
    logic [PTR_W-1:0] sel;
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < NUM_RS; i++) begin
      sel = PTR_W'((int'(ptr) + i) % NUM_RS);
      if (!found && req[sel]) begin
        found = 1'b1;
        win   = sel;
      end
    end
    return {found, win};
  endfunction

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] w);
    return PTR_W'((int'(w) + 1) % NUM_RS);
  endfunction

  // Grant path. Including reset in each avail term forces all grants low
  // while reset is held, whatever the rdy inputs say.
  always_comb begin
    mult_avail = reset && !flush && (mult_cnt_q == '0);
    // A BUSY unit that completes this cycle can accept the next op at once.
    mem_avail  = reset && !flush &&
                 ((mem_st_q == MEM_IDLE) || ((mem_st_q == MEM_BUSY) && mem_done));
    alu_avail  = reset && !flush && !cdb_stall;

    // Class priority mult > mem > ALU: earlier winners are masked out of later classes.
    {mult_hit, mult_win} = rr_pick(mult_avail ? rs_mult_rdy : {NUM_RS{1'b0}}, ptr_mult_q);
    mult_gnt = mult_hit ? (NUM_RS'(1) << mult_win) : {NUM_RS{1'b0}};

    {mem_hit, mem_win} = rr_pick(mem_avail ? (rs_mem_rdy & ~mult_gnt) : {NUM_RS{1'b0}},
                                 ptr_mem_q);
    mem_gnt = mem_hit ? (NUM_RS'(1) << mem_win) : {NUM_RS{1'b0}};

    {alu_hit, alu_win} = rr_pick(alu_avail ? (rs_alu_rdy & ~mult_gnt & ~mem_gnt)
                                           : {NUM_RS{1'b0}}, ptr_alu_q);
    alu_gnt = alu_hit ? (NUM_RS'(1) << alu_win) : {NUM_RS{1'b0}};

    ptr_mult_d = mult_hit ? ptr_next(mult_win) : ptr_mult_q;
    ptr_mem_d  = mem_hit  ? ptr_next(mem_win)  : ptr_mem_q;
    ptr_alu_d  = alu_hit  ? ptr_next(alu_win)  : ptr_alu_q;

    // Flush does not clear the countdown: the multiplier is physically occupied.
    mult_cnt_d = mult_cnt_q;
    if (mult_hit)
      mult_cnt_d = CNT_W'(MULT_LAT - 1);
    else if (mult_cnt_q != '0)
      mult_cnt_d = mult_cnt_q - CNT_W'(1);
  end

  // Memory occupancy FSM next-state.
  always_comb begin
    mem_st_d = mem_st_q;
    case (mem_st_q)
      MEM_IDLE:  if (mem_hit) mem_st_d = MEM_BUSY;
      MEM_BUSY: begin
        if (flush)         mem_st_d = mem_done ? MEM_IDLE : MEM_DRAIN;
        else if (mem_done) mem_st_d = mem_hit  ? MEM_BUSY : MEM_IDLE;
      end
      MEM_DRAIN: if (mem_done) mem_st_d = MEM_IDLE;
      default:   mem_st_d = MEM_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_st_q   <= MEM_IDLE;
      mult_cnt_q <= '0;
      ptr_mult_q <= '0;
      ptr_mem_q  <= '0;
      ptr_alu_q  <= '0;
    end else begin
      mem_st_q   <= mem_st_d;
      mult_cnt_q <= mult_cnt_d;
      ptr_mult_q <= ptr_mult_d;
      ptr_mem_q  <= ptr_mem_d;
      ptr_alu_q  <= ptr_alu_d;
    end
  end

  assign mult_free = mult_gnt;
  assign mem_free  = mem_gnt;
  assign ALU_free  = alu_gnt;
  assign mult_busy = (mult_cnt_q != '0);
  assign mem_state = mem_st_q;

`ifdef FU_SCHED_PERF_EN
  logic [15:0] alu_pc_q, alu_pc_d, mem_pc_q, mem_pc_d;
  logic [15:0] mult_pc_q, mult_pc_d, stall_pc_q, stall_pc_d;
  logic        any_rdy;

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
  endfunction

  always_comb begin
    any_rdy    = |{rs_alu_rdy, rs_mem_rdy, rs_mult_rdy};
    alu_pc_d   = sat_inc(alu_pc_q, alu_hit);
    mem_pc_d   = sat_inc(mem_pc_q, mem_hit);
    mult_pc_d  = sat_inc(mult_pc_q, mult_hit);
    stall_pc_d = sat_inc(stall_pc_q, any_rdy && !(alu_hit || mem_hit || mult_hit));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alu_pc_q   <= '0;
      mem_pc_q   <= '0;
      mult_pc_q  <= '0;
      stall_pc_q <= '0;
    end else begin
      alu_pc_q   <= alu_pc_d;
      mem_pc_q   <= mem_pc_d;
      mult_pc_q  <= mult_pc_d;
      stall_pc_q <= stall_pc_d;
    end
  end

  assign alu_grant_cnt  = alu_pc_q;
  assign mem_grant_cnt  = mem_pc_q;
  assign mult_grant_cnt = mult_pc_q;
  assign stall_cnt      = stall_pc_q;
`endif

endmodule
